// File: rtl/template_match_ctrl.sv
// Window sequencer for the template-match correlation datapath: feeds T_HEIGHT lines,
// follows each one through the fixed datapath latency, and sums the line results into window totals.
module template_match_ctrl #(
    parameter int PIXEL_SIZE    = 8,
    parameter int LINE_SIZE     = 8,
    parameter int NUM_TEMPLATES = 4,
    parameter int T_HEIGHT      = 8,
    parameter int PIPE_LAT      = 4,
    localparam int LW = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE,
    localparam int AW = LW + $clog2(T_HEIGHT),
    localparam int CW = $clog2(T_HEIGHT)
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic                               line_req,
    output logic [CW-1:0]                      line_idx,
    input  logic                               line_ack,
    input  logic [LW-1:0]                      I_square_sum_in,
    input  logic [LW-1:0]                      I_sum_in,
    input  logic [NUM_TEMPLATES-1:0][LW-1:0]   TxI_sum_in,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [AW-1:0]                      res_I_square,
    output logic [AW-1:0]                      res_I,
    output logic [NUM_TEMPLATES-1:0][AW-1:0]   res_TxI
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_LINE = CW'(T_HEIGHT - 1);

    state_t                           state;
    state_t                           state_next;
    logic [CW-1:0]                    fc;
    logic [CW-1:0]                    ac;
    logic [PIPE_LAT-1:0]              vp;
    logic [AW-1:0]                    acc_isq;
    logic [AW-1:0]                    acc_i;
    logic [NUM_TEMPLATES-1:0][AW-1:0] acc_txi;
    logic                             done_q;
    logic                             feed_ack;
    logic                             acc_en;
    logic                             last_feed;
    logic                             last_acc;

    // An ack only counts while a line is actually being requested.
    always_comb begin
        feed_ack  = line_ack && (state == FEED);
        acc_en    = vp[PIPE_LAT-1];
        last_feed = feed_ack && (fc == LAST_LINE);
        last_acc  = acc_en && (ac == LAST_LINE);
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        line_req   = 1'b0;
        res_valid  = 1'b0;
        line_idx   = fc;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = FEED;
            end
            FEED: begin
                line_req = 1'b1;
                if (last_feed) state_next = DRAIN;
            end
            DRAIN: begin
                if (last_acc) state_next = OUT;
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            fc      <= '0;
            ac      <= '0;
            vp      <= '0;
            done_q  <= 1'b0;
            acc_isq <= '0;
            acc_i   <= '0;
            acc_txi <= '0;
        end else begin
            state  <= state_next;
            vp     <= (vp << 1) | PIPE_LAT'(feed_ack);
            done_q <= (state == OUT) && res_ready;
            if ((state == IDLE) && start) begin
                fc      <= '0;
                ac      <= '0;
                acc_isq <= '0;
                acc_i   <= '0;
                acc_txi <= '0;
            end else begin
                if (feed_ack) fc <= last_feed ? '0 : fc + CW'(1);
                // vp's top bit marks the cycle the line acked PIPE_LAT cycles ago has its sums ready.
                if (acc_en) begin
                    ac      <= last_acc ? '0 : ac + CW'(1);
                    acc_isq <= acc_isq + AW'(I_square_sum_in);
                    acc_i   <= acc_i + AW'(I_sum_in);
                    for (int k = 0; k < NUM_TEMPLATES; k++) begin
                        acc_txi[k] <= acc_txi[k] + AW'(TxI_sum_in[k]);
                    end
                end
            end
        end
    end

    assign done         = done_q;
    assign res_I_square = acc_isq;
    assign res_I        = acc_i;
    assign res_TxI      = acc_txi;

endmodule

// File: tb/tb_template_match_ctrl.sv
// Bench for template_match_ctrl: a window-level model (ack times, accumulation due times, line sums)
// checked against the DUT every cycle, plus literal pins for latency and totals.
module tb_template_match_ctrl;

    localparam int PIXEL_SIZE = 8;
    localparam int LINE_SIZE  = 8;
    localparam int NT         = 4;
    localparam int T_HEIGHT   = 8;
    localparam int PIPE_LAT   = 4;
    localparam int LW = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;
    localparam int AW = LW + $clog2(T_HEIGHT);
    localparam int CW = $clog2(T_HEIGHT);
    localparam longint MAXV = (longint'(1) << LW) - 1;

    logic                     CLK = 1'b0;
    logic                     RST = 1'b1;
    logic                     start = 1'b0;
    logic                     busy;
    logic                     done;
    logic                     line_req;
    logic [CW-1:0]            line_idx;
    logic                     line_ack = 1'b0;
    logic [LW-1:0]            I_square_sum_in = '0;
    logic [LW-1:0]            I_sum_in = '0;
    logic [NT-1:0][LW-1:0]    TxI_sum_in = '0;
    logic                     res_valid;
    logic                     res_ready = 1'b0;
    logic [AW-1:0]            res_I_square;
    logic [AW-1:0]            res_I;
    logic [NT-1:0][AW-1:0]    res_TxI;

    template_match_ctrl #(
        .PIXEL_SIZE(PIXEL_SIZE), .LINE_SIZE(LINE_SIZE), .NUM_TEMPLATES(NT),
        .T_HEIGHT(T_HEIGHT), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .busy(busy), .done(done),
        .line_req(line_req), .line_idx(line_idx), .line_ack(line_ack),
        .I_square_sum_in(I_square_sum_in), .I_sum_in(I_sum_in), .TxI_sum_in(TxI_sum_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_I_square(res_I_square), .res_I(res_I), .res_TxI(res_TxI)
    );

    // Clock / reset block
    always #5 CLK = ~CLK;

    // Model state: cyc is the number of the most recent rising edge.
    typedef struct { int at; int idx; } dp_t;
    dp_t    exp_q[$];
    int     cyc = 0;
    bit     m_active = 0;
    bit     m_done = 0;
    int     n_acked = 0;
    int     n_accum = 0;
    longint exp_isq = 0;
    longint exp_i = 0;
    longint exp_txi[NT];
    int     mode = 0;
    int     checks = 0;
    int     errors = 0;
    bit     run_cmp = 0;

    function automatic longint v_isq(input int idx);
        case (mode)
            0: return 1;
            1: return 3 * idx + 1;
            2: return MAXV;
            default: return 2;
        endcase
    endfunction

    function automatic longint v_i(input int idx);
        case (mode)
            0: return 1;
            1: return idx + 1;
            2: return MAXV;
            default: return 2;
        endcase
    endfunction

    function automatic longint v_txi(input int idx, input int k);
        case (mode)
            0: return 1;
            1: return 4 * idx + k;
            2: return MAXV;
            default: return 2;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, cyc);
        end
    endtask

    // Window model: a line acked at edge t is due in the totals at edge t+PIPE_LAT;
    // the result is valid once all T_HEIGHT lines are in, until the consumer takes it.
    initial begin
        foreach (exp_txi[k]) exp_txi[k] = 0;
        forever begin
            @(posedge CLK);
            cyc++;
            if (RST) begin
                m_active = 0; m_done = 0; n_acked = 0; n_accum = 0;
                exp_q.delete();
                exp_isq = 0; exp_i = 0;
                foreach (exp_txi[k]) exp_txi[k] = 0;
            end else begin
                bit hs;
                hs = m_active && (n_accum == T_HEIGHT) && res_ready;
                m_done = hs;
                if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                    exp_isq += v_isq(exp_q[0].idx);
                    exp_i   += v_i(exp_q[0].idx);
                    foreach (exp_txi[k]) exp_txi[k] += v_txi(exp_q[0].idx, k);
                    n_accum++;
                    void'(exp_q.pop_front());
                end
                if (m_active && n_acked < T_HEIGHT && line_ack) begin
                    exp_q.push_back('{cyc + PIPE_LAT, n_acked});
                    n_acked++;
                end
                if (hs) begin
                    m_active = 0;
                end else if (!m_active && start) begin
                    m_active = 1; n_acked = 0; n_accum = 0;
                    exp_isq = 0; exp_i = 0;
                    foreach (exp_txi[k]) exp_txi[k] = 0;
                end
            end
        end
    end

    // Datapath stand-in: real line sums only in the cycle they are due, noise otherwise.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0 && exp_q[0].at == cyc + 1) begin
                I_square_sum_in = LW'(v_isq(exp_q[0].idx));
                I_sum_in        = LW'(v_i(exp_q[0].idx));
                for (int k = 0; k < NT; k++) TxI_sum_in[k] = LW'(v_txi(exp_q[0].idx, k));
            end else begin
                I_square_sum_in = LW'($urandom);
                I_sum_in        = LW'($urandom);
                for (int k = 0; k < NT; k++) TxI_sum_in[k] = LW'($urandom);
            end
        end
    end

    // Compare process
    initial begin
        bit exp_lr;
        bit exp_rv;
        forever begin
            @(negedge CLK);
            if (run_cmp) begin
                exp_lr = m_active && (n_acked < T_HEIGHT);
                exp_rv = m_active && (n_accum == T_HEIGHT);
                chk("busy", busy, m_active);
                chk("line_req", line_req, exp_lr);
                if (exp_lr || !m_active) chk("line_idx", line_idx, exp_lr ? n_acked : 0);
                chk("res_valid", res_valid, exp_rv);
                chk("done", done, m_done);
                if (exp_rv) begin
                    chk("res_I_square", res_I_square, exp_isq);
                    chk("res_I", res_I, exp_i);
                    for (int k = 0; k < NT; k++) chk("res_TxI", res_TxI[k], exp_txi[k]);
                end
            end
        end
    end

    // Driver tasks: entered and left #1 after a rising edge.
    task automatic idle(input int n);
        start = 0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic run_window(input int md, input logic [31:0] stall, input int ready_low,
                              input bit busy_start, input int abort_at,
                              output int rv_rel, output int done_rel,
                              output logic [AW-1:0] cap_isq, output logic [AW-1:0] cap_i,
                              output logic [AW-1:0] cap_t0, output logic [AW-1:0] cap_t3);
        int s;
        int rv;
        int k;
        bit fin;
        mode = md;
        rv = -1; rv_rel = -1; done_rel = -1; fin = 0;
        cap_isq = '0; cap_i = '0; cap_t0 = '0; cap_t3 = '0;
        start = 1; line_ack = 1; res_ready = 0;
        s = cyc + 1;
        for (int n = 0; n < 200 && !fin; n++) begin
            @(posedge CLK);
            #1;
            k = cyc + 1 - s;
            if (res_valid && rv < 0) begin
                rv = cyc + 1; rv_rel = rv - s;
                cap_isq = res_I_square; cap_i = res_I;
                cap_t0 = res_TxI[0]; cap_t3 = res_TxI[NT-1];
            end
            if (done) begin
                done_rel = cyc + 1 - s;
                fin = 1;
            end
            if (abort_at > 0 && k - 1 == abort_at) fin = 1;
            start     = busy_start && m_active;
            line_ack  = !(k < 32 && stall[k]);
            RST       = (abort_at > 0 && k == abort_at);
            res_ready = (rv >= 0) && (cyc + 1 >= rv + ready_low);
        end
        if (!fin) chk("window timeout", 0, 1);
        start = 0; RST = 0; res_ready = 0; line_ack = 1;
    endtask

    initial begin
        int rv_rel;
        int done_rel;
        logic [AW-1:0] c_isq, c_i, c_t0, c_t3;

        repeat (3) @(posedge CLK);
        #1;
        run_cmp = 1;
        chk("reset busy", busy, 0);
        chk("reset res_valid", res_valid, 0);
        chk("reset line_idx", line_idx, 0);
        RST = 0;
        line_ack = 1;
        idle(3);

        // Unit sums, no stalls, immediate accept
        run_window(0, 32'h0, 0, 0, 0, rv_rel, done_rel, c_isq, c_i, c_t0, c_t3);
        chk("t1 res_valid cycle", rv_rel, 13);
        chk("t1 done cycle", done_rel, 14);
        chk("t1 res_I", c_i, 8);
        chk("t1 res_I_square", c_isq, 8);
        chk("t1 res_TxI0", c_t0, 8);

        // Stalls after line 2 (3 cycles) and line 5 (1 cycle), indexed sums
        run_window(1, 32'h470, 0, 0, 0, rv_rel, done_rel, c_isq, c_i, c_t0, c_t3);
        chk("t2 res_valid cycle", rv_rel, 17);
        chk("t2 res_I", c_i, 36);
        chk("t2 res_I_square", c_isq, 92);
        chk("t2 res_TxI0", c_t0, 112);
        chk("t2 res_TxI3", c_t3, 136);
        idle(2);

        // Maximal line sums
        run_window(2, 32'h0, 0, 0, 0, rv_rel, done_rel, c_isq, c_i, c_t0, c_t3);
        chk("t3 res_I_square", c_isq, 4194296);
        chk("t3 res_I", c_i, 4194296);
        chk("t3 res_TxI3", c_t3, 4194296);
        idle(1);

        // Backpressure with start held high while busy
        run_window(1, 32'h0, 10, 1, 0, rv_rel, done_rel, c_isq, c_i, c_t0, c_t3);
        chk("t4 res_valid cycle", rv_rel, 13);
        chk("t4 done cycle", done_rel, 24);
        chk("t4 res_I", c_i, 36);
        idle(1);
        chk("t4 idle after done", busy, 0);

        // Reset mid-window, then a clean window
        run_window(1, 32'h0, 0, 0, 6, rv_rel, done_rel, c_isq, c_i, c_t0, c_t3);
        chk("t5 aborted no result", rv_rel, -1);
        chk("t5 busy after reset", busy, 0);
        run_window(3, 32'h0, 0, 0, 0, rv_rel, done_rel, c_isq, c_i, c_t0, c_t3);
        chk("t5 res_valid cycle", rv_rel, 13);
        chk("t5 res_I", c_i, 16);
        chk("t5 res_TxI0", c_t0, 16);

        // Spurious acks in IDLE must not start anything
        line_ack = 1;
        idle(6);
        chk("t6 idle busy", busy, 0);
        chk("t6 idle line_req", line_req, 0);

        run_cmp = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/template_match_ctrl.md
Name: template_match_ctrl

Overview:
- Sequences one template-match window through the correlation datapath (correlation line plus adder trees).
- Requests the T_HEIGHT image/template lines one at a time and tracks each line through the fixed datapath pipeline latency.
- Accumulates the per-line sums (I², I, T×I per template) into window totals and presents them on a valid/ready result port.

Parameters:
- PIXEL_SIZE, 8: pixel width in bits.
- LINE_SIZE, 8: pixels per line.
- NUM_TEMPLATES, 4: templates correlated in parallel.
- T_HEIGHT, 8: lines per window (≥2).
- PIPE_LAT, 4: cycles from line presented to datapath until its line sums are valid at the sum inputs (≥1).
- Derived: LW = $clog2(LINE_SIZE)+2*PIXEL_SIZE (line-sum width); AW = LW+$clog2(T_HEIGHT) (accumulator width); CW = $clog2(T_HEIGHT).

Ports:
- CLK, in, 1: clock, all logic on rising edge.
- RST, in, 1: synchronous, active-high reset.
- start, in, 1: begin a window; honoured only in IDLE.
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: one-cycle pulse when the result handshake completes.
- line_req, out, 1: controller requests that line line_idx be driven into the datapath.
- line_idx, out, CW: index of the requested line (0..T_HEIGHT-1).
- line_ack, in, 1: the requested line is on the datapath inputs this cycle.
- I_square_sum_in, in, LW: I² line sum from the datapath.
- I_sum_in, in, LW: I line sum from the datapath.
- TxI_sum_in, in, LW x [NUM_TEMPLATES]: T×I line sums from the datapath.
- res_valid, out, 1: window result valid.
- res_ready, in, 1: consumer accepts the result.
- res_I_square, out, AW: accumulated I².
- res_I, out, AW: accumulated I.
- res_TxI, out, AW x [NUM_TEMPLATES]: accumulated T×I per template.

Behaviour:
- Reset (RST=1 at an edge) applies in any state, including mid-window. It forces:
  - state=IDLE; busy, done, line_req, res_valid = 0; line_idx = 0;
  - all accumulators, line/accumulate counters and the valid shift register cleared.
  - In-flight datapath data is discarded; nothing reaches the result port.
- FSM states are IDLE, FEED, DRAIN, OUT.
- IDLE:
  - start=1 → FEED; clears accumulators, feed counter fc and accumulate counter ac.
  - start is ignored in every other state.
- FEED:
  - line_req=1, line_idx=fc.
  - On line_ack, fc increments.
  - line_ack with fc==T_HEIGHT-1 → DRAIN.
  - line_req may stay high for any number of cycles without ack (stall).
- Valid tracking:
  - PIPE_LAT-deep shift register vp, shifted every cycle.
  - Input bit is (line_ack & state==FEED).
  - line_ack while line_req=0 is ignored.
  - When vp[PIPE_LAT-1]=1, the sum inputs are sampled and added to the accumulators, and ac increments. This is the line acked PIPE_LAT cycles earlier.
- DRAIN:
  - line_req=0.
  - Leaves when the accumulation with ac==T_HEIGHT-1 occurs → OUT.
  - Accumulation also proceeds during FEED; feeding and draining overlap.
- OUT:
  - res_valid=1; result outputs are stable while res_valid=1 & res_ready=0.
  - On res_valid & res_ready, at the next edge: done=1 for one cycle, res_valid=0, state=IDLE.
  - start in that same cycle is ignored; start must be seen in IDLE.
- Result outputs hold their last value in IDLE; they are defined only while res_valid=1.
- Arithmetic:
  - Unsigned, zero-extend LW→AW. AW is sized so that T_HEIGHT maximal line sums cannot overflow; no saturation logic.
- Latency (start sampled at cycle 0, line_ack tied high):
  - acks occur at cycles 1..T_HEIGHT;
  - last accumulation occurs at cycle T_HEIGHT+PIPE_LAT;
  - res_valid rises at cycle T_HEIGHT+PIPE_LAT+1.
  - Defaults: res_valid at cycle 13.
- Back-to-back windows:
  - Minimum gap is one IDLE cycle after done.
  - The next window must not start before the previous result is accepted.

Test Plan:
- Reset and start: T_HEIGHT=8, PIPE_LAT=4, line_ack=1, res_ready=1, every sum input = 1. Pulse start at cycle 0 → line_idx steps 0..7 over cycles 1..8; res_valid at cycle 13 with res_I=res_I_square=res_TxI[k]=8; done pulse at cycle 14.
- Stalls: line_ack low for 3 cycles after line 2 and 1 cycle after line 5; I_sum_in equals line index+1 when valid → res_I=36; res_valid delayed exactly 4 cycles versus no-stall.
- Max values: all sum inputs = 2^LW−1 → res fields = 8·(2^LW−1), no overflow.
- Backpressure: res_ready low for 10 cycles → res_valid and outputs held constant; done only in the cycle after res_ready rises; start pulses while busy have no effect.
- Reset mid-window: RST asserted at cycle 6 of a window, then a new window with sums = 2 → res_I=16, no residue from the aborted window.
- Spurious ack: line_ack=1 while IDLE/DRAIN/OUT → no counter or accumulator change.
